// File: rtl/riscv_test_monitor.sv
// riscv-tests pass/fail monitor: PC-match or tohost completion, timeout watchdog, PC-stall hang detect.
// Verdict registered one cycle after the triggering edge; pure observer with no backpressure.
module riscv_test_monitor #(
   parameter int              XLEN        = 32,
   parameter int              MODE        = 0,
   parameter logic [XLEN-1:0] PASS_PC     = 'h44,
   parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000,
   parameter int              TIMEOUT     = 5000,
   parameter int              STALL_LIMIT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] gp,
   input  logic            st_valid,
   input  logic [XLEN-1:0] st_addr,
   input  logic [XLEN-1:0] st_data,
   output logic            done,
   output logic            pass,
   output logic            timeout,
   output logic            hang,
   output logic [XLEN-1:0] test_num,
   output logic [31:0]     cycles
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state;
   logic [XLEN-1:0] last_pc;
   logic [31:0]     stall_cnt;

   logic [31:0]     cycles_nxt;
   logic            pc_same;
   logic            complete;
   logic [XLEN-1:0] verdict;
   logic            verdict_ok;
   logic            is_hang;
   logic            is_tmo;

   always_comb begin
      cycles_nxt = 32'd1;
      pc_same    = 1'b0;
      if (state != S_IDLE) begin
         cycles_nxt = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
         pc_same    = (pc == last_pc);
      end
      if (MODE == 0) begin
         complete = (pc == PASS_PC);
         verdict  = gp;
      end else begin
         complete = st_valid && (st_addr == TOHOST_ADDR);
         verdict  = st_data;
      end
      verdict_ok = (verdict == XLEN'(1));
      // The first RUN sample has no previous PC, so it can never count as a stall.
      is_hang    = pc_same && (stall_cnt == 32'(STALL_LIMIT - 1));
      is_tmo     = (cycles_nxt == 32'(TIMEOUT));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         last_pc   <= '0;
         stall_cnt <= '0;
         cycles    <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         timeout   <= 1'b0;
         hang      <= 1'b0;
         test_num  <= '0;
      end else begin
         case (state)
            S_IDLE, S_RUN: begin
               if (en) begin
                  state     <= S_RUN;
                  cycles    <= cycles_nxt;
                  last_pc   <= pc;
                  stall_cnt <= pc_same ? stall_cnt + 32'd1 : 32'd0;
                  // Priority: completion, then hang, then timeout.
                  if (complete) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     pass     <= verdict_ok;
                     test_num <= verdict_ok ? '0 : (verdict >> 1);
                  end else if (is_hang) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     hang  <= 1'b1;
                  end else if (is_tmo) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     timeout <= 1'b1;
                  end
               end
            end
            S_DONE: state <= S_DONE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench: MODE 0 instance (short timeout/stall limit) and MODE 1 instance share one stimulus.
module tb_riscv_test_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] pc, gp, st_addr, st_data;
   logic        st_valid;

   logic        done0, pass0, tmo0, hang0;
   logic [31:0] tnum0, cyc0;
   logic        done1, pass1, tmo1, hang1;
   logic [31:0] tnum1, cyc1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   riscv_test_monitor #(.XLEN(32), .MODE(0), .PASS_PC(32'h44), .TOHOST_ADDR(32'h1000),
                        .TIMEOUT(20), .STALL_LIMIT(4)) dut0 (
      .clk(clk), .rst(rst), .en(en), .pc(pc), .gp(gp), .st_valid(st_valid),
      .st_addr(st_addr), .st_data(st_data), .done(done0), .pass(pass0),
      .timeout(tmo0), .hang(hang0), .test_num(tnum0), .cycles(cyc0));

   riscv_test_monitor #(.XLEN(32), .MODE(1), .PASS_PC(32'h44), .TOHOST_ADDR(32'h1000),
                        .TIMEOUT(5000), .STALL_LIMIT(64)) dut1 (
      .clk(clk), .rst(rst), .en(en), .pc(pc), .gp(gp), .st_valid(st_valid),
      .st_addr(st_addr), .st_data(st_data), .done(done1), .pass(pass1),
      .timeout(tmo1), .hang(hang1), .test_num(tnum1), .cycles(cyc1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; en = 1'b0; pc = '0; gp = '0;
      st_valid = 1'b0; st_addr = '0; st_data = '0;
      step(); step();
      rst = 1'b1;
   endtask

   initial begin
      do_reset();
      chk("rst_done0", 32'(done0), 0);
      chk("rst_cycles0", cyc0, 0);
      chk("rst_done1", 32'(done1), 0);
      step();
      chk("idle_cycles", cyc0, 0);

      // MODE 0 pass: PC 0,4,..,0x44 reaches PASS_PC on RUN cycle 18 with gp=1
      en = 1'b1;
      for (int i = 0; i < 18; i++) begin
         pc = 32'(i * 4);
         gp = (i == 17) ? 32'd1 : 32'd0;
         step();
         if (i == 16) begin
            chk("m0p_pre_done", 32'(done0), 0);
            chk("m0p_pre_cycles", cyc0, 17);
         end
      end
      chk("m0p_done", 32'(done0), 1);
      chk("m0p_pass", 32'(pass0), 1);
      chk("m0p_tnum", tnum0, 0);
      chk("m0p_cycles", cyc0, 18);
      chk("m0p_tmo", 32'(tmo0), 0);
      pc = 32'h8; gp = 32'd9;
      step(); step();
      chk("m0p_frozen_cycles", cyc0, 18);
      chk("m0p_frozen_pass", 32'(pass0), 1);

      // MODE 0 fail: gp=7 -> test_num 3
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 18; i++) begin
         pc = 32'(i * 4);
         gp = 32'd7;
         step();
      end
      chk("m0f_done", 32'(done0), 1);
      chk("m0f_pass", 32'(pass0), 0);
      chk("m0f_tnum", tnum0, 3);
      chk("m0f_tmo", 32'(tmo0), 0);
      chk("m0f_hang", 32'(hang0), 0);

      // MODE 1: foreign store ignored, tohost store with data 5 -> test_num 2
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pc = 32'h200 + 32'(i * 4);
         st_valid = (i == 2 || i == 4);
         st_addr  = (i == 2) ? 32'h2000 : 32'h1000;
         st_data  = (i == 2) ? 32'd1 : 32'd5;
         step();
         if (i == 2) chk("m1_ignore_done", 32'(done1), 0);
      end
      st_valid = 1'b0;
      chk("m1_done", 32'(done1), 1);
      chk("m1_pass", 32'(pass1), 0);
      chk("m1_tnum", tnum1, 2);
      chk("m1_cycles", cyc1, 5);

      do_reset();
      en = 1'b1;
      pc = 32'h200; st_valid = 1'b1; st_addr = 32'h1000; st_data = 32'd1;
      step();
      st_valid = 1'b0;
      chk("m1p_done", 32'(done1), 1);
      chk("m1p_pass", 32'(pass1), 1);
      chk("m1p_tnum", tnum1, 0);

      // Hang: PC held at 0x30, flagged on the 4th equal sample after the first
      do_reset();
      en = 1'b1;
      pc = 32'h0; step();
      pc = 32'h4; step();
      pc = 32'h30;
      for (int i = 0; i < 4; i++) step();
      chk("hang_pre_done", 32'(done0), 0);
      step();
      chk("hang_done", 32'(done0), 1);
      chk("hang_flag", 32'(hang0), 1);
      chk("hang_pass", 32'(pass0), 0);
      chk("hang_cycles", cyc0, 7);

      // Hang with a 10-cycle pause mid-stall
      do_reset();
      en = 1'b1;
      pc = 32'h0; step();
      pc = 32'h4; step();
      pc = 32'h30;
      for (int i = 0; i < 3; i++) step();
      en = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("pause_cycles", cyc0, 5);
      chk("pause_done", 32'(done0), 0);
      en = 1'b1;
      step();
      chk("pause_pre_done", 32'(done0), 0);
      step();
      chk("pause_hang", 32'(hang0), 1);
      chk("pause_hang_cycles", cyc0, 7);

      // Timeout at cycles=20
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pc = 32'h100 + 32'(i * 4);
         step();
         if (i == 18) chk("tmo_pre_done", 32'(done0), 0);
      end
      chk("tmo_flag", 32'(tmo0), 1);
      chk("tmo_done", 32'(done0), 1);
      chk("tmo_pass", 32'(pass0), 0);
      chk("tmo_cycles", cyc0, 20);

      // Completion on cycle 20 beats timeout
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pc = (i == 19) ? 32'h44 : 32'h100 + 32'(i * 4);
         gp = 32'd1;
         step();
      end
      chk("sim_pass", 32'(pass0), 1);
      chk("sim_tmo", 32'(tmo0), 0);
      chk("sim_cycles", cyc0, 20);

      // Asynchronous reset mid-run at cycles=9
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         pc = 32'h300 + 32'(i * 4);
         step();
      end
      chk("arst_pre_cycles", cyc0, 9);
      #2 rst = 1'b0;
      #1;
      chk("arst_cycles", cyc0, 0);
      chk("arst_done", 32'(done0), 0);
      #1 rst = 1'b1;
      pc = 32'h400;
      step();
      chk("arst_restart", cyc0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable pass/fail monitor for riscv-tests runs on the pipeline core. It replaces ad-hoc per-test bench checks with one parametrised block instantiated beside `Core`. The block observes PC, the `gp` (x3) register value and data-memory stores, and detects completion either by PC match or by a `tohost` store. It adds a cycle counter, a timeout watchdog and hang (PC-stall) detection, and reports a sticky verdict with the failing test number.

## Interface
Parameters:
- `XLEN`, 32: data/address width.
- `MODE`, 0: 0 = PC-match completion, 1 = `tohost` store completion.
- `PASS_PC`, 32'h44: completion PC in MODE 0.
- `TOHOST_ADDR`, 32'h1000: completion store address in MODE 1.
- `TIMEOUT`, 5000: maximum RUN cycles before a timeout verdict, ≥2.
- `STALL_LIMIT`, 64: consecutive cycles with unchanged PC that count as a hang, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; starts the run, and pauses it when low.
- `pc`  in  XLEN  current fetch PC of the core.
- `gp`  in  XLEN  current value of register x3.
- `st_valid`  in  1  data-memory store this cycle.
- `st_addr`  in  XLEN  store address.
- `st_data`  in  XLEN  store data.
- `done`  out  1  verdict available (sticky).
- `pass`  out  1  test passed (valid when `done`).
- `timeout`  out  1  ended by the `TIMEOUT` watchdog.
- `hang`  out  1  ended by PC stall.
- `test_num`  out  XLEN  failing test number (verdict value >> 1). 0 on pass, timeout or hang.
- `cycles`  out  32  RUN cycles elapsed; saturates at 32'hFFFF_FFFF.

## Operation
- **States:** IDLE → RUN → DONE. There is no exit from DONE except reset.
- **IDLE:** All outputs 0. Moves to RUN on the first edge with `en`=1. That edge is counted as RUN cycle 1, so `cycles` becomes 1.
- **RUN, `en`=1:**
  - `cycles` increments each edge.
  - The stall counter increments if `pc` equals the PC registered on the previous edge; otherwise it clears to 0.
- **RUN, `en`=0:** `cycles`, the stall counter and the last-PC register hold. No detection is performed.
- **Completion, MODE 0:** Triggers when `pc`==`PASS_PC`.
  - The verdict value is `gp`.
  - `pass` = (`gp`==1).
  - `test_num` = `gp`>>1 if not pass, else 0.
- **Completion, MODE 1:** Triggers when `st_valid` is high and `st_addr`==`TOHOST_ADDR`.
  - The verdict value is `st_data`; `pass` and `test_num` are derived as in MODE 0.
  - Stores to any other address are ignored.
- **Hang:** The stall counter reaches `STALL_LIMIT`−1 and `pc` is still unchanged. Sets `hang`=1, `pass`=0.
- **Timeout:** `cycles` reaches `TIMEOUT` without another trigger. Sets `timeout`=1, `pass`=0.
- **Simultaneous triggers:** Priority is completion > hang > timeout. Exactly one of {completion, `hang`, `timeout`} is recorded.
- **DONE:** `done`=1. All outputs, including `cycles`, are frozen. Inputs are ignored.
- **Reset mid-run:** An asynchronous clear to IDLE with all outputs and counters at 0, regardless of state.

## Timing
- All outputs are registered. The reset value of every output is 0.
- A trigger sampled at edge N gives `done`/`pass`/`timeout`/`hang`/`test_num` valid after edge N, i.e. one-cycle latency.
- `cycles` equals the number of RUN edges with `en`=1, including the triggering edge.
- A PC that settles at `PASS_PC` triggers on its first sampled cycle. The stall counter does not pre-empt it, because completion has priority.
- Hang is flagged on the `STALL_LIMIT`-th consecutive equal-PC sample: PC is unchanged across `STALL_LIMIT` edges after the first sample.
- Comparisons are full-width `XLEN` equality.

## Test plan
- **MODE 0 pass:** PC steps 0,4,8,… and reaches 0x44 at RUN cycle 18 with `gp`=1 → next cycle `done`=1, `pass`=1, `test_num`=0, `cycles`=18.
- **MODE 0 fail:** PC reaches 0x44 with `gp`=7 → `done`=1, `pass`=0, `test_num`=3, `timeout`=`hang`=0.
- **MODE 1:**
  - A store to 0x2000 with data 1 is ignored.
  - A later store to 0x1000 with data 5 → `done`=1, `pass`=0, `test_num`=2.
  - With data 1 instead → `pass`=1.
- **Hang then pause:**
  - `STALL_LIMIT`=4: PC is held at 0x30 for 4 samples → `hang`=1, `done`=1.
  - Repeat, with `en`=0 for 10 cycles mid-stall → the stall counter holds, and `hang` fires only after 4 enabled equal samples in total.
- **Timeout vs. simultaneous trigger:**
  - `TIMEOUT`=20 with PC never matching → `timeout`=1 at `cycles`=20.
  - Separate run: PC hits `PASS_PC` on cycle 20 with `gp`=1 → `pass`=1, `timeout`=0.
- **Reset mid-run:** Assert `rst`=0 asynchronously (between edges) at `cycles`=9 → all outputs 0 immediately. After release and `en`=1, `cycles` restarts from 1.
